seg7_scan_ctrl: RTL and testbench

- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-cathode digits.
- Holds a shadow digit buffer written over a valid/ready port and a display buffer that is scanned.
- Commits shadow to display only at frame boundaries, so the display never tears.
- Drives the decoder's 4-bit input plus one-hot digit enables, with a blanking gap between digits to suppress ghosting.

---
 rtl/seg7_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl - time-multiplexed hex display scanner.
//
// One shared hex-to-7-segment decoder is scanned across NUM_DIGITS common
// cathode digits. Each digit slot is a BLANK gap (all digits off, kills
// ghosting) followed by a SHOW window (one digit lit). Host writes land in a
// shadow buffer and are copied to the scanned display buffer only at a frame
// boundary, so a frame never shows half-updated content.
//
// Optional build macro: SEG7_LZ_BLANK_EN
//   When defined, leading zeros are suppressed: during SHOW a digit stays dark
//   when it and every higher digit hold 0. Digit 0 always lights. Scan timing
//   and frame_tick are identical in both builds.
//
// Timing: every output is a flop. The output flops are loaded from the
// next-state values, so during any cycle digit_en/nibble/frame_tick describe
// the scan state held in that same cycle.

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,     // 2..4
  parameter int DWELL_CYCLES = 1024,  // >= 1, lit cycles per digit
  parameter int BLANK_CYCLES = 16     // >= 1, dark cycles between digits
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [1:0]            wr_digit,
  input  logic [3:0]            wr_value,
  input  logic                  commit_req,
  output logic [3:0]            nibble,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_tick
);

  // Counter wide enough for the longer of the two phases.
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX   = 2'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [1:0]                     r_idx;
  logic [NUM_DIGITS-1:0][3:0]     r_shadow;
  logic [NUM_DIGITS-1:0][3:0]     r_display;
  logic                           r_pending;
  logic                           r_wr_ready;
  logic [3:0]                     r_nibble;
  logic [NUM_DIGITS-1:0]          r_digit_en;
  logic                           r_frame_tick;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t                         w_state_nx;
  logic [CNT_W-1:0]               w_cnt_nx;
  logic [1:0]                     w_idx_nx;
  logic                           w_wrap;
  logic                           w_wr_fire;
  logic                           w_commit;
  logic [NUM_DIGITS-1:0][3:0]     w_shadow_nx;
  logic [NUM_DIGITS-1:0][3:0]     w_display_nx;
  logic                           w_pending_nx;
  logic [3:0]                     w_nibble_nx;
  logic [NUM_DIGITS-1:0]          w_digit_en_nx;
  logic [NUM_DIGITS-1:0]          w_lz_keep;

  // Scan FSM next state: BLANK -> SHOW -> BLANK (next digit), wrapping per frame.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    w_idx_nx   = r_idx;
    w_wrap     = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nx = ST_SHOW;
          w_cnt_nx   = '0;
        end else begin
          w_state_nx = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nx = ST_BLANK;
          w_cnt_nx   = '0;
          if (r_idx == LAST_IDX) begin
            w_idx_nx = 2'd0;
            w_wrap   = 1'b1;
          end else begin
            w_idx_nx = r_idx + 2'd1;
          end
        end else begin
          w_state_nx = ST_SHOW;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the start of a frame.
        w_state_nx = ST_BLANK;
        w_cnt_nx   = '0;
        w_idx_nx   = 2'd0;
      end
    endcase
  end

  // Shadow write port, frame-boundary commit and the commit_pending flag.
  always_comb begin
    w_wr_fire   = wr_valid & r_wr_ready;
    // r_frame_tick is high in the first cycle of a new frame; copying on that
    // cycle's edge means a commit_req in the same cycle only sets pending and
    // waits a full frame.
    w_commit    = r_frame_tick & r_pending;
    w_shadow_nx = r_shadow;
    if (w_wr_fire) begin
      // Out-of-range indices match no slot: handshaken but dropped.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_digit == 2'(i)) begin
          w_shadow_nx[i] = wr_value;
        end else begin
          w_shadow_nx[i] = r_shadow[i];
        end
      end
    end else begin
      w_shadow_nx = r_shadow;
    end
    // Writes are stalled while pending, so r_shadow is final at commit time.
    if (w_commit) begin
      w_display_nx = r_shadow;
      w_pending_nx = 1'b0;
    end else begin
      w_display_nx = r_display;
      w_pending_nx = r_pending | commit_req;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic w_lz_seen;

  // Leading-zero mask: keep digit i only if some digit j >= i is nonzero.
  always_comb begin
    w_lz_seen = 1'b0;
    w_lz_keep = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_lz_seen    = w_lz_seen | (w_display_nx[i] != 4'h0);
      w_lz_keep[i] = w_lz_seen | (i == 0);
    end
  end
`else
  assign w_lz_keep = '1;
`endif

  // Decoder input and one-hot enable for the scan state held next cycle.
  always_comb begin
    w_nibble_nx   = 4'h0;
    w_digit_en_nx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nx == 2'(i)) begin
        w_nibble_nx = w_display_nx[i];
        if (w_state_nx == ST_SHOW) begin
          w_digit_en_nx[i] = w_lz_keep[i];
        end else begin
          w_digit_en_nx[i] = 1'b0;
        end
      end else begin
        w_digit_en_nx[i] = 1'b0;
      end
    end
  end

  // State, buffers and registered outputs; reset discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= '0;
      r_display    <= '0;
      r_pending    <= 1'b0;
      r_wr_ready   <= 1'b1;
      r_nibble     <= 4'h0;
      r_digit_en   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_idx        <= w_idx_nx;
      r_shadow     <= w_shadow_nx;
      r_display    <= w_display_nx;
      r_pending    <= w_pending_nx;
      r_wr_ready   <= ~w_pending_nx;
      r_nibble     <= w_nibble_nx;
      r_digit_en   <= w_digit_en_nx;
      r_frame_tick <= w_wrap;
    end
  end

  assign wr_ready   = r_wr_ready;
  assign nibble     = r_nibble;
  assign digit_en   = r_digit_en;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl - self-checking bench for seg7_scan_ctrl.
// The reference model tracks the cycle count since reset and derives the scan
// position arithmetically (frame = NUM_DIGITS slots of BLANK+DWELL cycles),
// plus plain arrays for the shadow/display buffers and a pending flag.
// Define SEG7_LZ_BLANK_EN for both DUT and bench to check suppression.

module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_digit;
  logic [3:0]    wr_value;
  logic          commit_req;
  logic [3:0]    nibble;
  logic [ND-1:0] digit_en;
  logic          frame_tick;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_digit  (wr_digit),
    .wr_value  (wr_value),
    .commit_req(commit_req),
    .nibble    (nibble),
    .digit_en  (digit_en),
    .frame_tick(frame_tick)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int t;               // cycles since reset release (0 = first cycle)
  int m_shadow[ND];
  int m_display[ND];
  bit m_pending;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
  endtask

  function automatic bit tick_now();
    return (t > 0) && (t % FRAME == 0);
  endfunction

  function automatic int cur_digit();
    return (t % FRAME) / SLOT;
  endfunction

  function automatic int exp_digit_en();
    int d;
    bit keep;
    d    = cur_digit();
    keep = 1'b1;
    if (((t % FRAME) % SLOT) < BL) return 0;
`ifdef SEG7_LZ_BLANK_EN
    keep = (d == 0);
    for (int j = d; j < ND; j++) if (m_display[j] != 0) keep = 1'b1;
`endif
    return keep ? (1 << d) : 0;
  endfunction

  task automatic check_outputs();
    check_eq("digit_en",   digit_en,   exp_digit_en());
    check_eq("nibble",     nibble,     m_display[cur_digit()]);
    check_eq("frame_tick", frame_tick, tick_now());
    check_eq("wr_ready",   wr_ready,   !m_pending);
    check_eq("onehot0",    $onehot0(digit_en), 1);
  endtask

  task automatic model_reset();
    t = 0;
    m_pending = 1'b0;
    for (int i = 0; i < ND; i++) begin
      m_shadow[i]  = 0;
      m_display[i] = 0;
    end
  endtask

  // Apply one clock edge to the model using the inputs the DUT sampled.
  task automatic model_step();
    bit commit;
    bit wr_ok;
    if (reset) begin
      model_reset();
    end else begin
      commit = tick_now() && m_pending;
      wr_ok  = wr_valid && !m_pending;
      if (commit) for (int i = 0; i < ND; i++) m_display[i] = m_shadow[i];
      if (wr_ok && (int'(wr_digit) < ND)) m_shadow[wr_digit] = int'(wr_value);
      if (commit) m_pending = 1'b0;
      else if (commit_req) m_pending = 1'b1;
      t++;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    wr_valid   = 1'b0;
    commit_req = 1'b0;
    reset      = 1'b0;
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic write_digit(input int d, input int v);
    wr_valid = 1'b1;
    wr_digit = 2'(d);
    wr_value = 4'(v);
    run_cycle();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    run_cycle();
    commit_req = 1'b0;
  endtask

  // Advance until the upcoming cycle sits at frame phase p (after the first frame).
  task automatic wait_phase(input int p);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      if ((t > 0) && (t % FRAME == p)) begin
        found = 1'b1;
        break;
      end
      run_cycle();
    end
    check_eq("wait_phase", found, 1);
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_digit = 2'd0; wr_value = 4'h0; commit_req = 1'b0;
    @(posedge clk);
    model_reset();
    #1;

    // Reset held: outputs idle, wr_ready high.
    for (int k = 0; k < 3; k++) run_cycle();
    // Free-running scan after release, covering at least one frame_tick.
    idle(FRAME + 5);

    // Write digits 3..0 = A,3,F,1 then commit.
    write_digit(3, 4'hA);
    write_digit(2, 4'h3);
    write_digit(1, 4'hF);
    write_digit(0, 4'h1);
    pulse_commit();
    // Stall: hold a write while pending; it lands once wr_ready returns.
    wr_valid = 1'b1; wr_digit = 2'd2; wr_value = 4'h7;
    for (int k = 0; k < FRAME + 5; k++) run_cycle();
    idle(FRAME + 5);

    // Commit request exactly on a frame_tick cycle waits a full frame.
    wait_phase(0);
    pulse_commit();
    idle(2 * FRAME + 5);

    // Write and commit in the same cycle.
    wait_phase(3);
    wr_valid = 1'b1; wr_digit = 2'd1; wr_value = 4'hC; commit_req = 1'b1;
    run_cycle();
    idle(FRAME + 5);

    // Reset mid-SHOW of digit 2 with a commit pending.
    wait_phase(1);
    write_digit(0, 4'h9);
    pulse_commit();
    wait_phase(2 * SLOT + BL + 3);
    reset = 1'b1;
    run_cycle();
    idle(FRAME + 5);

    // Leading-zero patterns: display 0,0,5,0 then all zeros.
    write_digit(3, 0); write_digit(2, 0); write_digit(1, 5); write_digit(0, 0);
    pulse_commit();
    idle(2 * FRAME + 5);
    write_digit(1, 0);
    pulse_commit();
    idle(2 * FRAME + 5);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 499) == 0);
      wr_valid   = $urandom_range(0, 1) != 0;
      wr_digit   = 2'($urandom_range(0, 3));
      wr_value   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      commit_req = ($urandom_range(0, 24) == 0) || (tick_now() && ($urandom_range(0, 1) != 0));
      run_cycle();
    end
    idle(FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
